// File: rtl/spec_rr_sequencer.sv
// Round-robin stimulus sequencer: shares one Galois LFSR among NUM_SPECS spec channels,
// one burst plus quiet gap per enabled channel, counting cycles with active channel outputs.
module spec_rr_sequencer #(
    parameter int unsigned NUM_SPECS = 10,
    parameter int unsigned BURST_LEN = 8,
    parameter int unsigned GAP_LEN   = 2,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NUM_SPECS-1:0] enable_mask,
    input  logic [NUM_SPECS-1:0] c_0,
    input  logic [NUM_SPECS-1:0] c_1,
    output logic [NUM_SPECS-1:0] a_0,
    output logic [NUM_SPECS-1:0] a_1,
    output logic [3:0]           sel,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          hit_count
);

    typedef enum logic [2:0] {StIdle, StPick, StDrive, StGap, StDone} state_e;

    localparam logic [15:0] BurstLast = 16'(BURST_LEN - 1);
    localparam logic [15:0] GapLast   = (GAP_LEN > 0) ? 16'(GAP_LEN - 1) : 16'd0;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    state_e               state_q, state_d;
    logic [NUM_SPECS-1:0] mask_q, mask_d;
    logic [NUM_SPECS-1:0] a0_q, a0_d, a1_q, a1_d;
    logic [4:0]           ptr_q, ptr_d;
    logic [3:0]           sel_q, sel_d;
    logic [15:0]          lfsr_q, lfsr_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [15:0]          hit_q, hit_d;

    logic        found;
    logic [3:0]  pick_idx;
    logic        drive_en;
    logic [3:0]  drive_sel;
    logic [1:0]  drive_bits;
    logic [15:0] c_any;
    logic [15:0] a0_full, a1_full;

    // Lowest enabled index at or above ptr; descending scan so the lowest match wins.
    always_comb begin
        found    = 1'b0;
        pick_idx = 4'd0;
        for (int i = int'(NUM_SPECS) - 1; i >= 0; i--) begin
            if (mask_q[i] && (5'(i) >= ptr_q)) begin
                found    = 1'b1;
                pick_idx = 4'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        ptr_d      = ptr_q;
        sel_d      = sel_q;
        lfsr_d     = lfsr_q;
        cnt_d      = cnt_q;
        hit_d      = hit_q;
        drive_en   = 1'b0;
        drive_sel  = sel_q;
        drive_bits = 2'b00;
        c_any      = 16'(c_0 | c_1);

        if (((state_q == StDrive) || (state_q == StGap)) && c_any[sel_q] && (hit_q != 16'hFFFF)) begin
            hit_d = hit_q + 16'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mask_d  = enable_mask;
                    hit_d   = 16'd0;
                    lfsr_d  = LFSR_SEED;
                    ptr_d   = 5'd0;
                    state_d = StPick;
                end
            end
            StPick: begin
                if (found) begin
                    sel_d      = pick_idx;
                    cnt_d      = 16'd0;
                    state_d    = StDrive;
                    drive_en   = 1'b1;
                    drive_sel  = pick_idx;
                    drive_bits = lfsr_q[1:0];
                end else begin
                    state_d = StDone;
                end
            end
            StDrive: begin
                lfsr_d = lfsr_step(lfsr_q);
                if (cnt_q == BurstLast) begin
                    cnt_d = 16'd0;
                    if (GAP_LEN == 0) begin
                        ptr_d   = 5'(sel_q) + 5'd1;
                        state_d = StPick;
                    end else begin
                        state_d = StGap;
                    end
                end else begin
                    cnt_d      = cnt_q + 16'd1;
                    drive_en   = 1'b1;
                    drive_bits = lfsr_d[1:0];
                end
            end
            StGap: begin
                if (cnt_q == GapLast) begin
                    ptr_d   = 5'(sel_q) + 5'd1;
                    state_d = StPick;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // a is registered: the value loaded here is what the channel sees next cycle.
        a0_full = 16'd0;
        a1_full = 16'd0;
        if (drive_en) begin
            a0_full[drive_sel] = drive_bits[0];
            a1_full[drive_sel] = drive_bits[1];
        end
        a0_d = a0_full[NUM_SPECS-1:0];
        a1_d = a1_full[NUM_SPECS-1:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            mask_q  <= '0;
            a0_q    <= '0;
            a1_q    <= '0;
            ptr_q   <= 5'd0;
            sel_q   <= 4'd0;
            lfsr_q  <= LFSR_SEED;
            cnt_q   <= 16'd0;
            hit_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            a0_q    <= a0_d;
            a1_q    <= a1_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
        end
    end

    assign a_0       = a0_q;
    assign a_1       = a1_q;
    assign sel       = sel_q;
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign hit_count = hit_q;

endmodule

// File: tb/tb_spec_rr_sequencer.sv
// Scoreboard bench for spec_rr_sequencer: per-cycle expectations are queued at run issue and
// popped by a monitor on every busy cycle; run totals are checked on the done pulse.
module tb_spec_rr_sequencer;

    localparam int N = 10;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [N-1:0]  enable_mask;
    logic [N-1:0]  c_0, c_1;
    logic [N-1:0]  a_0, a_1;
    logic [3:0]    sel;
    logic          busy, done;
    logic [15:0]   hit_count;

    spec_rr_sequencer #(
        .NUM_SPECS(N),
        .BURST_LEN(8),
        .GAP_LEN  (2),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .enable_mask(enable_mask),
        .c_0        (c_0),
        .c_1        (c_1),
        .a_0        (a_0),
        .a_1        (a_1),
        .sel        (sel),
        .busy       (busy),
        .done       (done),
        .hit_count  (hit_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [N-1:0] a0;
        logic [N-1:0] a1;
        logic [3:0]   sel;
        logic         done;
    } cyc_t;

    typedef struct {
        int          cyc;
        logic [15:0] hit;
    } run_t;

    cyc_t exp_q[$];
    run_t run_q[$];

    int vectors = 0;
    int errors  = 0;
    int bcyc    = 0;
    logic [3:0] sel_m;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Monitor: one expected record per busy cycle; run totals on done.
    cyc_t e;
    run_t r;
    always @(negedge clock) begin
        if (busy === 1'b1) begin
            bcyc++;
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_busy: busy=1 at run cycle %0d, required no further busy cycle", bcyc);
            end else begin
                e = exp_q.pop_front();
                if (a_0 !== e.a0 || a_1 !== e.a1 || sel !== e.sel || done !== e.done) begin
                    errors++;
                    $display("FAIL run_cycle_%0d: got a0=%h a1=%h sel=%0d done=%b, required a0=%h a1=%h sel=%0d done=%b",
                             bcyc, a_0, a_1, sel, done, e.a0, e.a1, e.sel, e.done);
                end
            end
            if (done === 1'b1) begin
                vectors++;
                if (run_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: done at run cycle %0d, required none", bcyc);
                end else begin
                    r = run_q.pop_front();
                    if (bcyc != r.cyc || hit_count !== r.hit) begin
                        errors++;
                        $display("FAIL run_total: got done_cycle=%0d hit_count=%0d, required done_cycle=%0d hit_count=%0d",
                                 bcyc, hit_count, r.cyc, r.hit);
                    end
                end
            end
        end else begin
            bcyc = 0;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Expected per-cycle records for one run with c held constant; at most limit records.
    task automatic gen_run(input logic [N-1:0] mask, input int limit);
        logic [15:0] lfsr;
        int          ptr;
        int          idx;
        int          n;
        cyc_t        rec;
        lfsr = 16'hACE1;
        ptr  = 0;
        n    = 0;
        forever begin
            idx = -1;
            for (int i = N - 1; i >= 0; i--) if (mask[i] && i >= ptr) idx = i;
            rec = '{a0: '0, a1: '0, sel: sel_m, done: 1'b0};
            if (n < limit) exp_q.push_back(rec);
            n++;
            if (idx < 0) begin
                rec = '{a0: '0, a1: '0, sel: sel_m, done: 1'b1};
                if (n < limit) exp_q.push_back(rec);
                n++;
                break;
            end
            sel_m = 4'(idx);
            for (int b = 0; b < 8; b++) begin
                rec = '{a0: '0, a1: '0, sel: sel_m, done: 1'b0};
                rec.a0[idx] = lfsr[0];
                rec.a1[idx] = lfsr[1];
                if (n < limit) exp_q.push_back(rec);
                n++;
                lfsr = lfsr_step(lfsr);
            end
            for (int g = 0; g < 2; g++) begin
                rec = '{a0: '0, a1: '0, sel: sel_m, done: 1'b0};
                if (n < limit) exp_q.push_back(rec);
                n++;
            end
            ptr = idx + 1;
        end
    endtask

    task automatic push_total(input int cyc, input logic [15:0] hit);
        run_t t;
        t.cyc = cyc;
        t.hit = hit;
        run_q.push_back(t);
    endtask

    task automatic start_run(input logic [N-1:0] mask);
        enable_mask = mask;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < budget) begin
            tick();
            k++;
        end
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", name, busy, budget);
        end
        vectors++;
        if (exp_q.size() != 0 || run_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d cycle records and %0d run totals left, required 0 and 0",
                     name, exp_q.size(), run_q.size());
        end
        exp_q.delete();
        run_q.delete();
    endtask

    task automatic check_idle(input string name, input logic [3:0] exp_sel, input logic [15:0] exp_hit);
        vectors++;
        if (a_0 !== '0 || a_1 !== '0 || busy !== 1'b0 || done !== 1'b0 ||
            sel !== exp_sel || hit_count !== exp_hit) begin
            errors++;
            $display("FAIL %s: got a0=%h a1=%h busy=%b done=%b sel=%0d hit=%0d, required a0=0 a1=0 busy=0 done=0 sel=%0d hit=%0d",
                     name, a_0, a_1, busy, done, sel, hit_count, exp_sel, exp_hit);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required run completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        enable_mask = '0;
        c_0         = '0;
        c_1         = '0;
        sel_m       = 4'd0;
        repeat (3) tick();
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            tick();
            check_idle("reset_idle", 4'd0, 16'd0);
        end

        // Single channel 0, c quiet.
        gen_run(10'h001, 1000);
        push_total(13, 16'd0);
        start_run(10'h001);
        wait_idle(300, "single");
        check_idle("single_after", 4'd0, 16'd0);

        // All channels, c_0 always active: 10 channels x 10 DRIVE+GAP cycles.
        c_0 = '1;
        gen_run(10'h3FF, 1000);
        push_total(112, 16'd100);
        start_run(10'h3FF);
        wait_idle(300, "all");
        check_idle("all_after", 4'd9, 16'd100);
        c_0 = '0;

        // Channels 0 and 9; a stray start in cycle 5 must be ignored.
        c_0 = 10'h200;
        c_1 = 10'h001;
        gen_run(10'h201, 1000);
        push_total(24, 16'd20);
        start_run(10'h201);
        repeat (4) tick();
        enable_mask = 10'h3FF;
        start       = 1'b1;
        tick();
        start       = 1'b0;
        wait_idle(300, "sparse");
        check_idle("sparse_after", 4'd9, 16'd20);
        c_0 = '0;
        c_1 = '0;

        // Empty mask.
        gen_run(10'h000, 1000);
        push_total(2, 16'd0);
        start_run(10'h000);
        wait_idle(300, "empty");
        check_idle("empty_after", 4'd9, 16'd0);

        // Reset during the 4th DRIVE cycle of channel 0 (run cycle 5).
        c_0 = '1;
        gen_run(10'h001, 5);
        start_run(10'h001);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        check_idle("mid_reset", 4'd0, 16'd0);
        reset = 1'b0;
        wait_idle(5, "mid_reset");
        c_0   = '0;
        sel_m = 4'd0;

        // Rerun must reproduce the single-channel scenario exactly.
        gen_run(10'h001, 1000);
        push_total(13, 16'd0);
        start_run(10'h001);
        wait_idle(300, "rerun");
        check_idle("rerun_after", 4'd0, 16'd0);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
